// File: rtl/mips_divider.sv
// mips_divider: iterative restoring divider for the MIPS div/divu path.
// One quotient bit per clock, WIDTH iterations from the capture edge to done.
// Optional feature macro: SIGNED_DIV_EN compiles in signed division
// (magnitude conversion of the operands and sign fixup of the results).
// Without it every operation is unsigned and is_signed is ignored.
module mips_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CALC = 1'b1
  } state_t;

`ifdef SIGNED_DIV_EN
  // Two's-complement negation used for magnitudes and sign fixup.
  function automatic logic [WIDTH-1:0] neg2(input logic [WIDTH-1:0] v);
    return (~v) + WIDTH'(1);
  endfunction
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;        // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;        // dividend bits shifting out, quotient bits in
  logic [WIDTH-1:0] dmag_q, dmag_d;      // divisor magnitude
  logic             dz_q, dz_d;          // captured divisor was zero
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;
  logic             done_q, done_d;
`ifdef SIGNED_DIV_EN
  logic             negq_q, negq_d;      // operand signs differ
  logic             negr_q, negr_d;      // dividend was negative
`else
  logic             unused_is_signed;
  assign unused_is_signed = is_signed;
`endif

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // One restoring step: shift {rem, quo} left, trial-subtract the divisor.
  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dmag_q};
    if (!trial[WIDTH]) begin
      rem_step = trial[WIDTH-1:0];
      quo_step = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_step = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
      quo_step = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Sign fixup of the final step; a negative dividend gives a negative remainder.
  always_comb begin
`ifdef SIGNED_DIV_EN
    quo_fix = negq_q ? neg2(quo_step) : quo_step;
    rem_fix = negr_q ? neg2(rem_step) : rem_step;
`else
    quo_fix = quo_step;
    rem_fix = rem_step;
`endif
  end

  // Next-state and datapath control: capture in IDLE, iterate in CALC.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dmag_d      = dmag_q;
    dz_d        = dz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    done_d      = 1'b0;
`ifdef SIGNED_DIV_EN
    negq_d      = negq_q;
    negr_d      = negr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CALC;
          cnt_d   = {CW{1'b0}};
          rem_d   = {WIDTH{1'b0}};
          dz_d    = (divisor == {WIDTH{1'b0}});
`ifdef SIGNED_DIV_EN
          negr_d  = is_signed & dividend[WIDTH-1];
          negq_d  = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          quo_d   = (is_signed & dividend[WIDTH-1]) ? neg2(dividend) : dividend;
          dmag_d  = (is_signed & divisor[WIDTH-1])  ? neg2(divisor)  : divisor;
`else
          quo_d   = dividend;
          dmag_d  = divisor;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          // Divide by zero: the remainder path already restores the original
          // dividend bits; only the quotient needs forcing to all ones.
          state_d     = S_IDLE;
          cnt_d       = {CW{1'b0}};
          quotient_d  = dz_q ? {WIDTH{1'b1}} : quo_fix;
          remainder_d = rem_fix;
          div_zero_d  = dz_q;
          done_d      = 1'b1;
        end else begin
          state_d = S_CALC;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CW{1'b0}};
      rem_q       <= {WIDTH{1'b0}};
      quo_q       <= {WIDTH{1'b0}};
      dmag_q      <= {WIDTH{1'b0}};
      dz_q        <= 1'b0;
      quotient_q  <= {WIDTH{1'b0}};
      remainder_q <= {WIDTH{1'b0}};
      div_zero_q  <= 1'b0;
      done_q      <= 1'b0;
`ifdef SIGNED_DIV_EN
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dmag_q      <= dmag_d;
      dz_q        <= dz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      done_q      <= done_d;
`ifdef SIGNED_DIV_EN
      negq_q      <= negq_d;
      negr_q      <= negr_d;
`endif
    end
  end

  assign busy      = (state_q == S_CALC);
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule
